// File: rtl/conv_output_streamer.sv
// Output side of the HW3 accelerator stream: one config beat, then conv results
// through a small FIFO under valid/ready backpressure, then a completion pulse.
module conv_output_streamer #(
    parameter int IMG_DIM    = 64,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 13
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_start,
    input  logic              i_cfg_legal,
    input  logic [1:0]        i_kernel_size,
    input  logic [1:0]        i_stride_size,
    input  logic [1:0]        i_dilation_size,
    input  logic              i_res_valid,
    input  logic [DATA_W-1:0] i_res_data,
    output logic              o_res_ready,
    output logic              o_cfg_valid,
    output logic [1:0]        o_kernel_size,
    output logic [1:0]        o_stride_size,
    output logic [1:0]        o_dilation_size,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    input  logic              i_out_ready,
    output logic              o_exe_finish
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] TOTAL_S1 = CNT_W'(IMG_DIM * IMG_DIM);
    localparam logic [CNT_W-1:0] TOTAL_S2 = CNT_W'((IMG_DIM / 2) * (IMG_DIM / 2));
    localparam logic [AW:0]      OCC_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        STREAM,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic              cfg_legal;
    logic [1:0]        kernel_q, stride_q, dilation_q;
    logic [CNT_W-1:0]  total, push_cnt, pop_cnt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       occ;
    logic              fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (occ == OCC_FULL);
    assign fifo_empty = (occ == '0);
    assign push       = i_res_valid && o_res_ready;
    assign pop        = o_out_valid && i_out_ready;
    // Gated so the data bus reads 0 whenever nothing valid is buffered
    assign o_out_data = o_out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nxt       = state;
        o_cfg_valid     = 1'b0;
        o_kernel_size   = 2'd0;
        o_stride_size   = 2'd0;
        o_dilation_size = 2'd0;
        o_res_ready     = 1'b0;
        o_out_valid     = 1'b0;
        o_exe_finish    = 1'b0;
        case (state)
            IDLE: begin
                if (i_cfg_start) state_nxt = CFG;
            end
            CFG: begin
                o_cfg_valid = 1'b1;
                if (cfg_legal) begin
                    o_kernel_size   = kernel_q;
                    o_stride_size   = stride_q;
                    o_dilation_size = dilation_q;
                    state_nxt       = STREAM;
                end else begin
                    state_nxt = DONE;
                end
            end
            STREAM: begin
                o_res_ready = !fifo_full && (push_cnt < total);
                o_out_valid = !fifo_empty;
                if (o_out_valid && i_out_ready && (pop_cnt == total - CNT_W'(1)))
                    state_nxt = DONE;
            end
            DONE: begin
                o_exe_finish = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cfg_legal  <= 1'b0;
            kernel_q   <= '0;
            stride_q   <= '0;
            dilation_q <= '0;
            total      <= '0;
            push_cnt   <= '0;
            pop_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_cfg_start) begin
                cfg_legal  <= i_cfg_legal;
                kernel_q   <= i_kernel_size;
                stride_q   <= i_stride_size;
                dilation_q <= i_dilation_size;
            end
            if (state == CFG) begin
                total    <= (stride_q == 2'd2) ? TOTAL_S2 : TOTAL_S1;
                push_cnt <= '0;
                pop_cnt  <= '0;
            end else begin
                if (push) push_cnt <= push_cnt + CNT_W'(1);
                if (pop)  pop_cnt  <= pop_cnt + CNT_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_res_data;
    end

endmodule

// File: tb/tb_conv_output_streamer.sv
// Randomised bench for conv_output_streamer: a queue-based scoreboard predicts
// every config beat, result beat, handshake and completion pulse.
module tb_conv_output_streamer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_cfg_start, i_cfg_legal;
    logic [1:0] i_kernel_size, i_stride_size, i_dilation_size;
    logic       i_res_valid;
    logic [7:0] i_res_data;
    logic       o_res_ready, o_cfg_valid;
    logic [1:0] o_kernel_size, o_stride_size, o_dilation_size;
    logic       o_out_valid;
    logic [7:0] o_out_data;
    logic       i_out_ready, o_exe_finish;

    int n_checks = 0;
    int n_fail   = 0;

    conv_output_streamer #(
        .IMG_DIM(64),
        .DATA_W(8),
        .FIFO_DEPTH(4),
        .CNT_W(13)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_cfg_start(i_cfg_start),
        .i_cfg_legal(i_cfg_legal),
        .i_kernel_size(i_kernel_size),
        .i_stride_size(i_stride_size),
        .i_dilation_size(i_dilation_size),
        .i_res_valid(i_res_valid),
        .i_res_data(i_res_data),
        .o_res_ready(o_res_ready),
        .o_cfg_valid(o_cfg_valid),
        .o_kernel_size(o_kernel_size),
        .o_stride_size(o_stride_size),
        .o_dilation_size(o_dilation_size),
        .o_out_valid(o_out_valid),
        .o_out_data(o_out_data),
        .i_out_ready(i_out_ready),
        .o_exe_finish(o_exe_finish)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {12'd0, o_res_ready, o_cfg_valid, o_kernel_size, o_stride_size,
                o_dilation_size, o_out_valid, o_out_data, o_exe_finish};
    endfunction

    // mode: 0 always ready, 1 ready toggles 1010, 2 random, 3 hold-then-drain A1..,
    //       4 random with reset after 100 beats, 5 random with stray cfg_start
    task automatic run_job(input bit legal, input logic [1:0] k, input logic [1:0] s,
                           input logic [1:0] d, input int mode);
        logic [7:0] q[$];
        int total, pushed, popped, cyc, budget;
        bit v, r;
        logic [7:0] dat;

        @(negedge i_clk);
        i_cfg_start = 1'b1; i_cfg_legal = legal;
        i_kernel_size = k; i_stride_size = s; i_dilation_size = d;
        @(negedge i_clk);
        i_cfg_start = 1'b0;
        #1;
        check_eq("cfg_valid", o_cfg_valid, 1);
        check_eq("cfg_sizes", {o_kernel_size, o_stride_size, o_dilation_size},
                 legal ? {k, s, d} : 6'd0);
        check_eq("cfg_no_out", {o_out_valid, o_exe_finish, o_res_ready}, 0);

        if (!legal) begin
            @(negedge i_clk); #1;
            check_eq("illegal_finish", o_exe_finish, 1);
            check_eq("illegal_quiet", {o_cfg_valid, o_out_valid, o_res_ready}, 0);
            @(negedge i_clk); #1;
            check_eq("illegal_idle", all_outputs(), 0);
            return;
        end

        total  = (s == 2'd2) ? 1024 : 4096;
        budget = total * 4 + 200;
        pushed = 0; popped = 0; cyc = 0;
        while (popped < total && cyc < budget) begin
            @(negedge i_clk);
            cyc++;
            if (mode == 4 && popped == 100) begin
                i_rst = 1'b1;
                #1;
                check_eq("midreset_outputs", all_outputs(), 0);
                @(negedge i_clk);
                i_rst = 1'b0; i_res_valid = 1'b0; i_out_ready = 1'b0;
                return;
            end
            dat = 8'($urandom);
            case (mode)
                0:       begin v = 1'b1; r = 1'b1; end
                1:       begin v = 1'b1; r = (cyc % 2) == 1; end
                3:       begin v = 1'b1; r = (cyc > 8); dat = 8'(8'hA1 + pushed); end
                default: begin v = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
            endcase
            if (mode == 5 && cyc == 50) begin
                i_cfg_start = 1'b1; i_cfg_legal = 1'b1;
                i_kernel_size = 2'd1; i_stride_size = 2'd1; i_dilation_size = 2'd1;
            end else begin
                i_cfg_start = 1'b0;
            end
            i_res_valid = v; i_res_data = dat; i_out_ready = r;
            #1;
            check_eq("res_ready", o_res_ready, (pushed < total) && (q.size() < 4));
            check_eq("out_valid", o_out_valid, q.size() > 0);
            if (q.size() > 0) check_eq("out_data", o_out_data, q[0]);
            check_eq("stream_quiet", {o_cfg_valid, o_exe_finish}, 0);
            if (mode == 3 && cyc == 8) begin
                check_eq("hold_full", o_res_ready, 0);
                check_eq("hold_head", o_out_data, 8'hA1);
            end
            if (o_out_valid && r) begin
                void'(q.pop_front());
                popped++;
            end
            if (v && o_res_ready) begin
                q.push_back(dat);
                pushed++;
            end
        end
        check_eq("beats_done", popped, total);
        check_eq("pushes_done", pushed, total);
        i_cfg_start = 1'b0;
        @(negedge i_clk);
        i_res_valid = 1'b0; i_out_ready = 1'b0;
        #1;
        check_eq("finish_pulse", o_exe_finish, 1);
        check_eq("finish_quiet", {o_out_valid, o_res_ready, o_cfg_valid}, 0);
        @(negedge i_clk); #1;
        check_eq("back_idle", all_outputs(), 0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_cfg_start = 1'b0; i_cfg_legal = 1'b0;
        i_kernel_size = '0; i_stride_size = '0; i_dilation_size = '0;
        i_res_valid = 1'b0; i_res_data = '0; i_out_ready = 1'b0;
        #1;
        check_eq("reset_outputs", all_outputs(), 0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        check_eq("idle_outputs", all_outputs(), 0);

        run_job(1'b1, 2'd3, 2'd1, 2'd1, 0);
        run_job(1'b1, 2'd3, 2'd2, 2'd2, 1);
        run_job(1'b0, 2'd3, 2'd1, 2'd2, 0);
        run_job(1'b1, 2'd1, 2'd2, 2'd1, 3);
        run_job(1'b1, 2'd2, 2'd2, 2'd1, 4);
        run_job(1'b1, 2'd2, 2'd2, 2'd1, 2);
        run_job(1'b1, 2'd3, 2'd2, 2'd2, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_output_streamer.md
Name: conv_output_streamer

Overview:
- Transmit end of the HW3 accelerator's external stream.
- The controller sequences the input side (image/weight load via i_in_valid). This block drives the output side.
- After barcode decode it emits one configuration beat, then streams convolution results over a valid/ready interface, then pulses o_exe_finish.
- Results arrive from the conv engine through an internal FIFO that decouples engine timing from downstream backpressure.

Parameters:
- IMG_DIM, 64, input image edge length in pixels.
- DATA_W, 8, result pixel width.
- FIFO_DEPTH, 4, result FIFO entries (power of 2).
- CNT_W, 13, width of beat counters; must hold IMG_DIM*IMG_DIM.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock, asynchronous, active-high.
- i_cfg_start  in  1  one-cycle pulse when barcode decode completes.
- i_cfg_legal  in  1  decoded barcode is legal; sampled with i_cfg_start.
- i_kernel_size  in  2  decoded kernel size; sampled with i_cfg_start.
- i_stride_size  in  2  decoded stride (1 or 2); sampled with i_cfg_start.
- i_dilation_size  in  2  decoded dilation (1 or 2); sampled with i_cfg_start.
- i_res_valid  in  1  conv engine result beat valid.
- i_res_data  in  DATA_W  conv engine result pixel.
- o_res_ready  out  1  FIFO accepts result this cycle.
- o_cfg_valid  out  1  configuration beat valid (exactly one cycle).
- o_kernel_size  out  2  config output; zero when illegal.
- o_stride_size  out  2  config output; zero when illegal.
- o_dilation_size  out  2  config output; zero when illegal.
- o_out_valid  out  1  result beat valid.
- o_out_data  out  DATA_W  result beat data.
- i_out_ready  in  1  downstream accepts result beat.
- o_exe_finish  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, i_rst=1):
  - State returns to IDLE.
  - FIFO is flushed; all counters and config registers are cleared.
  - Every output is 0.
  - Reset mid-stream discards all buffered and pending data; no o_exe_finish is issued.
- States: IDLE -> CFG -> STREAM -> DONE -> IDLE.
- IDLE:
  - On i_cfg_start, latch i_cfg_legal and the three size fields, then go to CFG.
  - i_cfg_start in any other state is ignored.
- CFG (one cycle):
  - o_cfg_valid=1; o_*_size carry the latched values if legal, else 2'd0.
  - Legal: load TOTAL = (IMG_DIM/stride)^2 (stride 1 -> 4096, stride 2 -> 1024), clear push/pop counters, go to STREAM.
  - Illegal: go to DONE.
- STREAM:
  - Push: o_res_ready = !fifo_full && (push_cnt < TOTAL). A push occurs when i_res_valid && o_res_ready; push_cnt increments.
  - o_res_ready is 0 in all other states.
  - Pop: o_out_valid = !fifo_empty. o_out_data = FIFO head, driven combinationally from the storage array.
  - A pop occurs when o_out_valid && i_out_ready; pop_cnt increments.
  - While o_out_valid=1 and i_out_ready=0, o_out_data must hold stable.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Full is evaluated on registered occupancy, so there is no push into a full FIFO even if a pop occurs that cycle.
  - Latency: a result pushed into an empty FIFO appears on o_out_valid in the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is log2(FIFO_DEPTH)+1.
  - When the pop with pop_cnt == TOTAL-1 is accepted, go to DONE.
- DONE (one cycle): o_exe_finish=1, then IDLE.
  - Illegal path: o_exe_finish asserts the cycle after o_cfg_valid, with no o_out_valid ever asserted.
- o_cfg_valid and o_exe_finish are never high in the same cycle as o_out_valid.

Test Plan:
- Legal k=3, s=1, d=1; i_res_valid and i_out_ready held at 1 -> o_cfg_valid for 1 cycle with 3/1/1, then exactly 4096 beats in order with data matching the pushed sequence, and o_exe_finish 1 cycle after the last beat.
- Legal s=2, d=2; i_out_ready toggling 1010... -> 1024 beats, no duplication or loss, o_out_data stable across stalls, o_res_ready deasserts after the 1024th push.
- Illegal code (i_cfg_legal=0) -> o_cfg_valid with all sizes 0, o_exe_finish the next cycle, o_out_valid and o_res_ready stay 0.
- Hold i_out_ready=0, push 0xA1..0xA4 -> o_res_ready falls after 4 pushes and o_out_valid=1 with data 0xA1. Raise i_out_ready -> 0xA1..0xA4 appear on consecutive cycles, then o_res_ready returns to 1.
- Assert i_rst after 100 beats in STREAM -> all outputs 0 immediately; a new i_cfg_start gives a fresh CFG beat and a full TOTAL count.
- i_cfg_start pulsed during STREAM -> ignored; beat count and config are unchanged.
